// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: FSM state encodings and parameter legality helpers.
// Imported by the transmitter and its FIFO; intended for reuse by a receive path.
package uart_defs;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int data_w, input int fifo_depth,
                                        input int clks_per_bit, input int stop_bits);
        return (data_w >= 5) && (data_w <= 9) &&
               (fifo_depth >= 2) && is_pow2(fifo_depth) &&
               (clks_per_bit >= 2) &&
               ((stop_bits == 1) || (stop_bits == 2));
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous circular FIFO with registered level/full/empty flags.
// Read data is the current head entry; rd_en pops it at the next edge.
module uart_sync_fifo
    import uart_defs::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    if (!is_pow2(FIFO_DEPTH) || FIFO_DEPTH < 2) begin : g_depth_check
        $error("uart_sync_fifo: FIFO_DEPTH must be a power of two and at least 2");
    end

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LW-1:0]     level_d;
    logic              wr_ok;
    logic              rd_ok;

    // Refusal is decided on the registered flags only, so a pop in the same
    // cycle never frees a slot for a write presented while full.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_d = level;
        case ({wr_ok, rd_ok})
            2'b10:   level_d = level + LW'(1);
            2'b01:   level_d = level - LW'(1);
            default: level_d = level;
        endcase
    end

    always_ff @(posedge clock) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_d;
            full  <= (level_d == LW'(FIFO_DEPTH));
            empty <= (level_d == '0);
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: queues core writes in a FIFO and serialises them
// LSB first with a start bit and STOP_BITS stop bits; all outputs registered.
//
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit, line low for one bit period
//   DATA  | shifting out DATA_W payload bits, LSB first
//   STOP  | line high for STOP_BITS bit periods; done on the last cycle
module uart_tx_buffered
    import uart_defs::*;
#(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          full,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          tx,
    output logic                          busy,
    output logic                          done
);

    localparam int STOP_CYC = CLKS_PER_BIT * STOP_BITS;
    localparam int CNT_W    = $clog2(STOP_CYC) + 1;
    localparam int IDX_W    = $clog2(DATA_W);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

    if (!params_legal(DATA_W, FIFO_DEPTH, CLKS_PER_BIT, STOP_BITS)) begin : g_param_check
        $error("uart_tx_buffered: illegal DATA_W/FIFO_DEPTH/CLKS_PER_BIT/STOP_BITS");
    end

    uart_state_t       state_q;
    uart_state_t       state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  idx_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic              pop;
    logic              tx_d;
    logic              busy_d;
    logic              done_d;

    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_full;

    uart_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .level   (level),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign full = fifo_full;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_q == STOP_LAST) begin
                    cnt_d = '0;
                    // Chain straight into the next frame so there is no idle gap.
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next-state values and registered, so they
    // line up with the state they describe.
    always_comb begin
        tx_d   = 1'b1;
        busy_d = (state_d != IDLE);
        done_d = (state_d == STOP) && (cnt_d == STOP_LAST);
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tx       <= tx_d;
            busy     <= busy_d;
            done     <= done_d;
            overflow <= overflow | (wr_en & fifo_full);
        end
    end

endmodule
